// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) arithmetic helpers.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam logic [7:0] INV_C0   = 8'h0E;
    localparam logic [7:0] INV_C1   = 8'h0B;
    localparam logic [7:0] INV_C2   = 8'h0D;
    localparam logic [7:0] INV_C3   = 8'h09;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply; the constant coefficient folds this down in synthesis.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_gf_mat_mul.sv
// Combinational InvMixColumns of one 32-bit column (byte 0 in the MSBs).
module inv_gf_mat_mul
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] res
);

    localparam logic [7:0] COEF [4] = '{INV_C0, INV_C1, INV_C2, INV_C3};

    // Row r uses the coefficient vector rotated right by r positions.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [7:0] acc;
        always_comb begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) begin
                acc = acc ^ gf_mul(col[31-8*c -: 8], COEF[(4 + c - r) % 4]);
            end
        end
        assign res[31-8*r -: 8] = acc;
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one column per cycle through a shared column multiplier.
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    state_t       state;
    state_t       state_next;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic         capture;
    logic         step;

    always_comb begin
        case (cnt)
            2'd0:    col_in = work[127:96];
            2'd1:    col_in = work[95:64];
            2'd2:    col_in = work[63:32];
            default: col_in = work[31:0];
        endcase
    end

    inv_gf_mat_mul u_mat (
        .col (col_in),
        .res (col_out)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        capture    = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            work  <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                work <= in_state;
                cnt  <= 2'd0;
            end else if (step) begin
                // cnt rolls back to 0 as BUSY exits, so it never addresses a 5th column.
                cnt <= cnt + 2'd1;
                case (cnt)
                    2'd0:    work[127:96] <= col_out;
                    2'd1:    work[95:64]  <= col_out;
                    2'd2:    work[63:32]  <= col_out;
                    default: work[31:0]   <= col_out;
                endcase
            end
        end
    end

    assign out_state = work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq, plus a round trip through a forward MixColumns model.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int n_cmp = 0;
    int n_err = 0;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3,
                m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3)};
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic feed(input logic [127:0] din);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_feed", in_ready, 1'b1);
        in_valid = 1'b1;
        in_state = din;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walks edges 1..4 after acceptance; ends at the negedge after edge 4.
    task automatic wait_result(input logic [127:0] exp, input bit full);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (full) begin
                check("busy_out_valid", out_valid, 1'b0);
                check("busy_in_ready", in_ready, 1'b0);
            end
        end
        @(negedge clk);
        check("done_out_valid", out_valid, 1'b1);
        check("done_out_state", out_state, exp);
    endtask

    task automatic run(input logic [127:0] din, input logic [127:0] exp, input bit full);
        feed(din);
        wait_result(exp, full);
        @(negedge clk);
        if (full) begin
            check("idle_in_ready", in_ready, 1'b1);
            check("idle_out_valid", out_valid, 1'b0);
        end
    endtask

    localparam logic [127:0] V_IN   = 128'h5f72641557f5bc92f7be3b291db9f91a;
    localparam logic [127:0] V_OUT  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] C_IN   = {4{32'h046681e5}};
    localparam logic [127:0] C_OUT  = {4{32'hd4bf5d30}};
    localparam logic [127:0] ONES   = {16{8'h01}};
    localparam logic [127:0] ZEROS  = '0;

    initial begin
        logic [127:0] s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, ZEROS);
        rst = 1'b0;
        @(negedge clk);

        run(V_IN, V_OUT, 1'b1);
        run(C_IN, C_OUT, 1'b1);
        run(ONES, ONES, 1'b1);
        run(ZEROS, ZEROS, 1'b1);

        // Backpressure in DONE
        out_ready = 1'b0;
        feed(V_IN);
        wait_result(V_OUT, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_state", out_state, V_OUT);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);

        // in_valid during BUSY and DONE is ignored
        out_ready = 1'b0;
        feed(C_IN);
        in_valid = 1'b1;
        in_state = V_IN;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ign_busy_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check("ign_done_out_valid", out_valid, 1'b1);
        check("ign_done_out_state", out_state, C_OUT);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ign_done_hold_state", out_state, C_OUT);
            check("ign_done_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("ign_idle_in_ready", in_ready, 1'b1);
        check("ign_idle_state_kept", out_state, C_OUT);

        // Reset mid-BUSY
        feed(V_IN);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_state", out_state, ZEROS);
        check("abort_in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("abort_hold_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        run(V_IN, V_OUT, 1'b1);

        // Round trip against a forward MixColumns model
        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            run(fwd_mix(s), s, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
